// File: rtl/yresp_checker.sv
// Response checker: compares the DUT output bus y against a golden stream, folds y into a MISR
// signature, and reports pass/fail after NUM_VECTORS beats. Optional macro: YRESP_MASK_EN (per-bit compare mask).
//
// Handshake: a beat happens in RUN when y_valid & exp_valid are both high on a rising clk edge;
// exp_ready = RUN & y_valid, so y_valid without exp_valid is a stall and consumes nothing.
module yresp_checker #(
  parameter int                 Y_WIDTH     = 421,
  parameter int                 SIG_WIDTH   = 32,
  parameter logic [SIG_WIDTH-1:0] POLY      = 32'h04C11DB7,
  parameter int                 NUM_VECTORS = 21,
  parameter int                 CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 y_valid,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic                 exp_valid,
  input  logic [Y_WIDTH-1:0]   exp_y,
`ifdef YRESP_MASK_EN
  input  logic [Y_WIDTH-1:0]   exp_mask,
`endif
  output logic                 exp_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_WIDTH-1:0] mismatch_cnt,
  output logic [CNT_WIDTH-1:0] first_fail_idx,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [1:0]           state_dbg
);

  localparam int NSLICE = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PADW   = NSLICE * SIG_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] idx;
  logic [PADW-1:0]      y_pad;
  logic [SIG_WIDTH-1:0] fold;
  logic [SIG_WIDTH-1:0] sig_nxt;
  logic [Y_WIDTH-1:0]   diff;
  logic                 mism;
  logic                 beat;
  logic                 clear;
  logic                 last_beat;

  // Fold y into SIG_WIDTH-bit slices; the top slice is zero-padded.
  always_comb begin
    y_pad = '0;
    y_pad[Y_WIDTH-1:0] = y;
    fold = '0;
    for (int i = 0; i < NSLICE; i++) begin
      fold = fold ^ y_pad[i*SIG_WIDTH +: SIG_WIDTH];
    end
    sig_nxt = {signature[SIG_WIDTH-2:0], 1'b0}
            ^ (signature[SIG_WIDTH-1] ? POLY : '0)
            ^ fold;
  end

  always_comb begin
    diff = y ^ exp_y;
`ifdef YRESP_MASK_EN
    diff = diff & ~exp_mask;
`endif
    mism = |diff;
  end

  assign beat      = (state == S_RUN) && y_valid && exp_valid;
  assign clear     = start && (state != S_RUN);
  assign last_beat = beat && (idx == CNT_WIDTH'(NUM_VECTORS - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last_beat) state_nxt = S_DONE;
      S_DONE:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state == S_RUN);
    done      = (state == S_DONE);
    exp_ready = (state == S_RUN) && y_valid;
    pass      = (state == S_DONE) && (mismatch_cnt == '0);
    state_dbg = state;
  end

  // Counters and signature; all frozen outside a beat.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx            <= '0;
      mismatch_cnt   <= '0;
      first_fail_idx <= '1;
      signature      <= '0;
    end else if (beat) begin
      signature <= sig_nxt;
      idx       <= idx + 1'b1;
      if (mism) begin
        if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
        if (first_fail_idx == '1) first_fail_idx <= idx;
      end
    end
  end

endmodule

// File: tb/tb_yresp_checker.sv
// Directed + randomized bench for yresp_checker against a behavioural model of the run rules.
module tb_yresp_checker;

  localparam int          YW   = 421;
  localparam int          NV   = 21;
  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          y_valid;
  logic [YW-1:0] y;
  logic          exp_valid;
  logic [YW-1:0] exp_y;
  logic [YW-1:0] exp_mask;
  logic          exp_ready;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   mismatch_cnt;
  logic [15:0]   first_fail_idx;
  logic [31:0]   signature;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the run
  bit          m_run, m_done;
  int          m_idx;
  int          m_cnt;
  int          m_ffi;   // -1 means no failure seen
  logic [31:0] m_sig;

  always #5 clk = ~clk;

  yresp_checker dut (
    .clk(clk), .rst(rst), .start(start),
    .y_valid(y_valid), .y(y),
    .exp_valid(exp_valid), .exp_y(exp_y),
`ifdef YRESP_MASK_EN
    .exp_mask(exp_mask),
`endif
    .exp_ready(exp_ready), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_idx(first_fail_idx),
    .signature(signature), .state_dbg(state_dbg)
  );

  function automatic logic [31:0] ref_misr(input logic [31:0] s, input logic [YW-1:0] v);
    logic [31:0] f;
    logic [31:0] r;
    f = '0;
    for (int b = 0; b < YW; b++) f[b % 32] = f[b % 32] ^ v[b];
    r = s << 1;
    if (s[31]) r = r ^ POLY;
    return r ^ f;
  endfunction

  function automatic logic [YW-1:0] rand_y();
    logic [447:0] t;
    for (int k = 0; k < 14; k++) t[k*32 +: 32] = $urandom;
    return t[YW-1:0];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_idx = 0; m_cnt = 0; m_ffi = -1; m_sig = '0;
  endtask

  task automatic model_clock(input logic r, input logic st, input logic yv, input logic ev,
                             input logic [YW-1:0] yy, input logic [YW-1:0] ee,
                             input logic [YW-1:0] mm);
    logic [YW-1:0] eff_mask;
    eff_mask = '0;
`ifdef YRESP_MASK_EN
    eff_mask = mm;
`endif
    if (r) begin
      model_reset();
    end else if (!m_run) begin
      if (st) begin
        model_reset();
        m_run = 1;
      end
    end else if (yv && ev) begin
      m_sig = ref_misr(m_sig, yy);
      if (((yy ^ ee) & ~eff_mask) != '0) begin
        if (m_cnt < 16'hFFFF) m_cnt++;
        if (m_ffi < 0) m_ffi = m_idx;
      end
      m_idx++;
      if (m_idx == NV) begin
        m_run  = 0;
        m_done = 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".busy"}, 64'(busy), 64'(m_run));
    check({tag, ".done"}, 64'(done), 64'(m_done));
    check({tag, ".pass"}, 64'(pass), 64'(m_done && (m_cnt == 0)));
    check({tag, ".cnt"},  64'(mismatch_cnt), 64'(m_cnt));
    check({tag, ".ffi"},  64'(first_fail_idx), (m_ffi < 0) ? 64'hFFFF : 64'(m_ffi));
    check({tag, ".sig"},  64'(signature), 64'(m_sig));
  endtask

  // One clock: drive, check combinational exp_ready, clock, update model, check registers.
  task automatic step(input string tag, input logic r, input logic st, input logic yv,
                      input logic ev, input logic [YW-1:0] yy, input logic [YW-1:0] ee,
                      input logic [YW-1:0] mm);
    rst = r; start = st; y_valid = yv; exp_valid = ev; y = yy; exp_y = ee; exp_mask = mm;
    #1;
    check({tag, ".exp_ready"}, 64'(exp_ready), 64'(m_run && yv));
    @(posedge clk);
    model_clock(r, st, yv, ev, yy, ee, mm);
    #1;
    check_all(tag);
  endtask

  task automatic idle_step(input string tag, input logic st);
    step(tag, 1'b0, st, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic match_beat(input string tag);
    logic [YW-1:0] v;
    v = rand_y();
    step(tag, 1'b0, 1'b0, 1'b1, 1'b1, v, v, '0);
  endtask

  initial begin
    logic [YW-1:0] v;
    logic [YW-1:0] e;
    logic [YW-1:0] m;
    logic [YW-1:0] one;
    logic [31:0]   sig_hold;
    logic [15:0]   cnt_hold;
    logic          yv, ev, st, r;
    int            guard;

    one = '0;
    one[0] = 1'b1;
    rst = 1; start = 0; y_valid = 0; exp_valid = 0; y = '0; exp_y = '0; exp_mask = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.exp_ready", 64'(exp_ready), 64'd0);

    // Reset in the middle of a run
    idle_step("t1.start", 1'b1);
    for (int i = 0; i < 5; i++) match_beat("t1.beat");
    step("t1.rst", 1'b1, 1'b0, 1'b1, 1'b1, rand_y(), rand_y(), '0);
    check("t1.sig_zero", 64'(signature), 64'd0);
    check("t1.ffi_ones", 64'(first_fail_idx), 64'hFFFF);

    // All-zero run: signature stays zero and passes
    idle_step("t2.start", 1'b1);
    for (int i = 0; i < NV; i++) step("t2.beat", 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    check("t2.done", 64'(done), 64'd1);
    check("t2.pass", 64'(pass), 64'd1);
    check("t2.sig", 64'(signature), 64'd0);
    idle_step("t2.hold", 1'b0);

    // Mismatches on beats 3 and 7
    idle_step("t3.start", 1'b1);
    for (int i = 0; i < NV; i++) begin
      v = rand_y();
      e = v;
      if (i == 3 || i == 7) v[0] = ~v[0];
      step("t3.beat", 1'b0, 1'b0, 1'b1, 1'b1, v, e, '0);
    end
    check("t3.pass", 64'(pass), 64'd0);
    check("t3.cnt", 64'(mismatch_cnt), 64'd2);
    check("t3.ffi", 64'(first_fail_idx), 64'd3);

    // Signature of single-bit inputs, then stalls and an ignored start
    idle_step("t4.start", 1'b1);
    step("t4.b0", 1'b0, 1'b0, 1'b1, 1'b1, one, one, '0);
    check("t4.sig1", 64'(signature), 64'h1);
    step("t4.b1", 1'b0, 1'b0, 1'b1, 1'b1, '0, '0, '0);
    check("t4.sig2", 64'(signature), 64'h2);
    sig_hold = signature;
    cnt_hold = mismatch_cnt;
    for (int i = 0; i < 4; i++) step("t5.stall", 1'b0, 1'b1, 1'b1, 1'b0, rand_y(), rand_y(), '0);
    check("t5.sig_hold", 64'(signature), 64'(sig_hold));
    check("t5.cnt_hold", 64'(mismatch_cnt), 64'(cnt_hold));
    check("t5.busy", 64'(busy), 64'd1);
    for (int i = 2; i < NV; i++) match_beat("t5.beat");
    check("t5.done", 64'(done), 64'd1);

    // Masked LSB difference on every beat
    idle_step("t6.start", 1'b1);
    for (int i = 0; i < NV; i++) begin
      v = rand_y();
      step("t6.beat", 1'b0, 1'b0, 1'b1, 1'b1, v, v ^ one, one);
    end
`ifdef YRESP_MASK_EN
    check("t6.cnt", 64'(mismatch_cnt), 64'd0);
    check("t6.pass", 64'(pass), 64'd1);
`else
    check("t6.cnt", 64'(mismatch_cnt), 64'd21);
    check("t6.pass", 64'(pass), 64'd0);
`endif

    // Randomized runs with stalls, sparse mismatches, masks, stray starts and resets
    for (int run = 0; run < 8; run++) begin
      idle_step("rnd.start", 1'b1);
      guard = 0;
      while (!m_done && guard < 200) begin
        v  = rand_y();
        e  = v;
        m  = '0;
        if ($urandom_range(4, 0) == 0) e = v ^ (one << $urandom_range(YW - 1, 0));
        if ($urandom_range(3, 0) == 0) m = rand_y();
        yv = ($urandom_range(9, 0) < 7);
        ev = ($urandom_range(9, 0) < 7);
        st = ($urandom_range(7, 0) == 0);
        r  = ($urandom_range(149, 0) == 0);
        step("rnd", r, st, yv, ev, v, e, m);
        if (!m_run && !m_done) idle_step("rnd.restart", 1'b1);
        guard++;
      end
      idle_step("rnd.hold", 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
